// File: rtl/shared_counter_pkg.sv
// Shared definitions for the multi-writer counter.
//   op_t  : per-channel opcode (NOP / LOAD / ADD / SUB)
//   OP_W  : opcode field width per channel
package shared_counter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

endpackage

// File: rtl/shared_counter_arb_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// The pointer names the highest-priority channel; the search wraps from it
// upwards. On an advance strobe the pointer moves to one past the winner.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (ptr -> 0)
//   req     : per-channel requests
//   advance : consume the current grant and rotate priority
//   gnt     : one-hot grant, combinational from req and ptr (0 when req=0)
module rr_arbiter #(
  parameter int NCH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] gnt
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NCH; i++) begin
      // candidate = (ptr + i) mod NCH, kept one bit wider to see the wrap
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NCH)) begin
        cand = cand - (PW+1)'(NCH);
      end
      if (!found && req[cand[PW-1:0]]) begin
        gnt[cand[PW-1:0]] = 1'b1;
        gnt_idx           = cand[PW-1:0];
        found             = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (gnt_idx == PW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/shared_counter_arb.sv
// Multi-writer shared counter. NCH channels request LOAD/ADD/SUB operations;
// a round-robin arbiter grants one per cycle and the granted operation is
// applied at that rising edge. ovf pulses for one cycle after an ADD carry
// or SUB borrow.
// Build option: SHARED_COUNTER_SAT_EN -- clamp to all-ones / zero instead of
// wrapping (ovf still pulses).
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   req    : per-channel request, bit i = channel i
//   op     : per-channel opcode, channel i at [2i+1:2i]
//   wrdata : per-channel operand, channel i at [WIDTH*i +: WIDTH]
//   gnt    : one-hot grant (combinational from req and priority pointer)
//   value  : registered counter value
//   ovf    : registered overflow/underflow pulse
module shared_counter_arb
  import shared_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [OP_W*NCH-1:0]  op,
  input  logic [WIDTH*NCH-1:0] wrdata,
  output logic [NCH-1:0]       gnt,
  output logic [WIDTH-1:0]     value,
  output logic                 ovf
);

  op_t              sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] nxt_value;
  logic             nxt_ovf;
  logic             any_gnt;

  assign any_gnt = |gnt;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (any_gnt),
    .gnt     (gnt)
  );

  // grant is one-hot, so a priority-free OR-style mux is sufficient
  always_comb begin
    sel_op   = OP_NOP;
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt[k]) begin
        sel_op   = op_t'(op[OP_W*k +: OP_W]);
        sel_data = wrdata[WIDTH*k +: WIDTH];
      end
    end
  end

  // top bit of sum is the carry, top bit of diff is the borrow
  assign sum  = {1'b0, value} + {1'b0, sel_data};
  assign diff = {1'b0, value} - {1'b0, sel_data};

  always_comb begin
    nxt_value = value;
    nxt_ovf   = 1'b0;
    case (sel_op)
      OP_LOAD: nxt_value = sel_data;
      OP_ADD: begin
        nxt_ovf = sum[WIDTH];
`ifdef SHARED_COUNTER_SAT_EN
        nxt_value = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        nxt_value = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        nxt_ovf = diff[WIDTH];
`ifdef SHARED_COUNTER_SAT_EN
        nxt_value = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        nxt_value = diff[WIDTH-1:0];
`endif
      end
      default: nxt_value = value;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (any_gnt) begin
      value <= nxt_value;
      ovf   <= nxt_ovf;
    end else begin
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shared_counter_arb.sv
// Scoreboard bench for shared_counter_arb (WIDTH=8, NCH=3).
// Driver issues one cycle of stimulus, predicts the grant from a reference
// model and queues the expected outputs; the monitor pops and compares on
// every falling edge.
module tb_shared_counter_arb;

  localparam int WIDTH = 8;
  localparam int NCH   = 3;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       req;
  logic [2*NCH-1:0]     op;
  logic [WIDTH*NCH-1:0] wrdata;
  logic [NCH-1:0]       gnt;
  logic [WIDTH-1:0]     value;
  logic                 ovf;

  always #5 clk = ~clk;

  shared_counter_arb #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op     (op),
    .wrdata (wrdata),
    .gnt    (gnt),
    .value  (value),
    .ovf    (ovf)
  );

  typedef struct {
    logic [NCH-1:0]   gnt;
    logic [WIDTH-1:0] value;
    logic             ovf;
    bit               known;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int m_val   = 0;
  bit m_ovf   = 0;
  int m_ptr   = 0;
  bit m_known = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] model_gnt(input logic [NCH-1:0] r);
    logic [NCH-1:0] g;
    g = '0;
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (m_ptr + i) % NCH;
      if (r[c]) begin
        g[c] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic void model_apply(input int o, input int d);
    int s;
    m_ovf = 0;
    case (o)
      1: m_val = d;
      2: begin
        s = m_val + d;
        if (s > MAXV) begin
          m_ovf = 1;
`ifdef SHARED_COUNTER_SAT_EN
          s = MAXV;
`else
          s = s - (MAXV + 1);
`endif
        end
        m_val = s;
      end
      3: begin
        if (d > m_val) begin
          m_ovf = 1;
`ifdef SHARED_COUNTER_SAT_EN
          m_val = 0;
`else
          m_val = m_val - d + (MAXV + 1);
`endif
        end else begin
          m_val = m_val - d;
        end
      end
      default: ;
    endcase
  endfunction

  // Drive one cycle; called just after a rising edge, returns just after the next.
  task automatic cycle(input logic r, input logic [NCH-1:0] rq,
                       input logic [2*NCH-1:0] o, input logic [WIDTH*NCH-1:0] d,
                       output logic [NCH-1:0] g);
    exp_t e;
    rst    = r;
    req    = rq;
    op     = o;
    wrdata = d;
    g      = model_gnt(rq);
    e.gnt   = g;
    e.value = m_val[WIDTH-1:0];
    e.ovf   = m_ovf;
    e.known = m_known;
    expq.push_back(e);
    @(posedge clk);
    if (r) begin
      m_val = 0; m_ovf = 0; m_ptr = 0; m_known = 1;
    end else if (g != '0) begin
      for (int k = 0; k < NCH; k++) begin
        if (g[k]) begin
          model_apply(int'(o[2*k +: 2]), int'(d[WIDTH*k +: WIDTH]));
          m_ptr = (k + 1) % NCH;
        end
      end
    end else begin
      m_ovf = 0;
    end
    #1;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cmp("gnt", 32'(gnt), 32'(e.gnt));
        if (e.known) begin
          cmp("value", 32'(value), 32'(e.value));
          cmp("ovf", 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    logic [NCH-1:0]   g;
    bit               act [NCH];
    logic [1:0]       ro  [NCH];
    logic [WIDTH-1:0] rd  [NCH];
    logic [NCH-1:0]   lastg;
    logic [NCH-1:0]   rq;
    logic [2*NCH-1:0] rop;
    logic [WIDTH*NCH-1:0] rdat;

    rst = 1'b1; req = '0; op = '0; wrdata = '0;
    @(posedge clk); #1;

    // reset with garbage requests
    cycle(1'b1, 3'b111, 6'b111001, 24'hA55AC3, g);
    cycle(1'b1, 3'b111, 6'b111001, 24'hA55AC3, g);
    cmp("rst_value", 32'(value), 32'h00);
    cmp("rst_ovf", 32'(ovf), 32'h0);

    // load then add
    cycle(1'b0, 3'b001, {2'b00, 2'b00, 2'b01}, {8'h00, 8'h00, 8'h40}, g);
    cmp("load_value", 32'(value), 32'h40);
    cycle(1'b0, 3'b010, {2'b00, 2'b10, 2'b00}, {8'h00, 8'h05, 8'h00}, g);
    cmp("add_value", 32'(value), 32'h45);
    cmp("add_ovf", 32'(ovf), 32'h0);
    cycle(1'b0, 3'b000, '0, '0, g);
    cmp("idle_value", 32'(value), 32'h45);

    // all three add 1 continuously from ptr=0
    cycle(1'b1, 3'b000, '0, '0, g);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 3'b111, {2'b10, 2'b10, 2'b10}, {8'h01, 8'h01, 8'h01}, g);
      cmp("rr_gnt", 32'(g), 32'(1 << (i % 3)));
      cmp("rr_value", 32'(value), 32'(i + 1));
    end

    // wrap / clamp on add
    cycle(1'b0, 3'b001, {2'b00, 2'b00, 2'b01}, {8'h00, 8'h00, 8'hFE}, g);
    cycle(1'b0, 3'b010, {2'b00, 2'b10, 2'b00}, {8'h00, 8'h03, 8'h00}, g);
`ifdef SHARED_COUNTER_SAT_EN
    cmp("add_ovf_value", 32'(value), 32'hFF);
`else
    cmp("add_ovf_value", 32'(value), 32'h01);
`endif
    cmp("add_ovf_flag", 32'(ovf), 32'h1);
    cycle(1'b0, 3'b000, '0, '0, g);
    cmp("ovf_pulse_clear", 32'(ovf), 32'h0);

    // wrap / clamp on sub
    cycle(1'b0, 3'b001, {2'b00, 2'b00, 2'b01}, {8'h00, 8'h00, 8'h01}, g);
    cycle(1'b0, 3'b010, {2'b00, 2'b11, 2'b00}, {8'h00, 8'h02, 8'h00}, g);
`ifdef SHARED_COUNTER_SAT_EN
    cmp("sub_ovf_value", 32'(value), 32'h00);
`else
    cmp("sub_ovf_value", 32'(value), 32'hFF);
`endif
    cmp("sub_ovf_flag", 32'(ovf), 32'h1);

    // reset during a held request
    cycle(1'b1, 3'b100, {2'b01, 2'b00, 2'b00}, {8'h99, 8'h00, 8'h00}, g);
    cmp("rst_mid_value", 32'(value), 32'h00);
    cycle(1'b0, 3'b100, {2'b01, 2'b00, 2'b00}, {8'h99, 8'h00, 8'h00}, g);
    cmp("rst_mid_regrant", 32'(value), 32'h99);

    // randomized traffic obeying the hold-until-granted handshake
    for (int c = 0; c < NCH; c++) begin
      act[c] = 0; ro[c] = '0; rd[c] = '0;
    end
    lastg = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (lastg[c] || !act[c]) begin
          act[c] = ($urandom_range(0, 2) != 0);
          ro[c]  = 2'($urandom_range(0, 3));
          rd[c]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255))
                                               : 8'($urandom_range(0, 255));
        end else if ($urandom_range(0, 15) == 0) begin
          act[c] = 0;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        rq[c]                 = act[c];
        rop[2*c +: 2]         = ro[c];
        rdat[WIDTH*c +: WIDTH] = rd[c];
      end
      if ($urandom_range(0, 99) == 0) begin
        cycle(1'b1, rq, rop, rdat, g);
        lastg = '0;
      end else begin
        cycle(1'b0, rq, rop, rdat, g);
        lastg = g;
      end
    end

    rst = 1'b0; req = '0;
    for (int w = 0; w < 10 && expq.size() > 0; w++) @(negedge clk);
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_counter_arb.md
# shared_counter_arb

Parametrised multi-writer counter register for shared state between independent processes. N writer channels request load, add or subtract operations. A registered round-robin arbiter grants exactly one request per cycle, so simultaneous writes never merge. Sits beside the process sequencers as their common event or position counter, with an over/underflow flag for the owning controller.

## Interface
- WIDTH, default 8: counter and data width in bits (≥2).
- NCH, default 2: number of writer channels (≥1).
- clk  in  1: sole clock; all state updates on rising edge.
- rst  in  1: reset is synchronous and active-high; one clock.
- req  in  NCH: per-channel request; bit i belongs to channel i.
- op  in  2*NCH: per-channel opcode, channel i at bits [2i+1:2i].
- wrdata  in  WIDTH*NCH: per-channel operand, channel i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
- gnt  out  NCH: one-hot grant. Combinational from req and the priority pointer.
- value  out  WIDTH: registered counter value.
- ovf  out  1: registered pulse. High for one cycle after an operation wrapped, or clamped when saturation is enabled.

## Operation
- Opcodes:
  - OP_NOP=00: grant consumed, value unchanged.
  - OP_LOAD=01: value←wrdata.
  - OP_ADD=10: value←value+wrdata.
  - OP_SUB=11: value←value−wrdata.
- Arbitration: round-robin over req.
  - Pointer ptr holds the highest-priority channel.
  - Search order: ptr, ptr+1, … NCH−1, 0, … ptr−1.
  - gnt is the first requesting channel in that order. gnt=0 when req=0.
- On a rising edge with gnt[k]=1:
  - Apply channel k's op and wrdata.
  - ptr←(k+1) mod NCH.
- No request: value and ptr hold; ovf←0.
- Arithmetic: unsigned, computed at WIDTH+1 bits.
  - ADD overflow: carry out set.
  - SUB underflow: borrow set (wrdata > value).
  - Without saturation, the result wraps mod 2^WIDTH.
- ovf←1 when the granted ADD/SUB overflows or underflows, else 0. LOAD and NOP never set ovf.
- Handshake:
  - A channel holds req, op and wrdata stable until it sees gnt[i]=1 at a rising edge.
  - The operation completes at that edge.
  - The channel drops req the following cycle or presents a new op.
  - A req dropped before grant is simply withdrawn; no side effect.
- Fairness: with all NCH channels requesting continuously, each is granted exactly once per NCH cycles.

## Timing
- Reset (rst=1 at edge): value=0, ptr=0, ovf=0. Pending requests are ignored that cycle.
- gnt in the rst cycle is still computed, but no update occurs.
- Latency: op visible on value one cycle after the granted edge. ovf valid in the same cycle as the new value.
- Back-to-back grants to different channels on consecutive cycles are supported, each seeing the previous result.
- Same channel re-granted on consecutive cycles only when it is the sole requester.
- rst during a held request: request is not performed, and its grant is re-arbitrated from ptr=0 next cycle.
- No combinational path from wrdata/op to any output. req→gnt is combinational only.

## Configuration
- SHARED_COUNTER_SAT_EN defined:
  - ADD overflow clamps value to 2^WIDTH−1.
  - SUB underflow clamps value to 0.
  - ovf still pulses on clamp.
- Undefined: modular wrap as above.
- Arbitration and handshake identical in both builds.

## Structure
- Package shared_counter_pkg: op_t (2-bit enum OP_NOP/OP_LOAD/OP_ADD/OP_SUB) and the opcode width constant.
- Sub-module rr_arbiter:
  - Parameter NCH.
  - Ports clk, rst, req, gnt, plus an advance strobe.
  - Owns ptr; reusable by other shared resources.
- Top level holds the operand mux, the WIDTH+1 adder/subtractor, the saturation logic and the output registers.

## Test plan
- WIDTH=8, NCH=3 for all scenarios.
- Reset: drive garbage req/ops with rst=1 for 2 cycles -> value=0x00, ovf=0, ptr=0.
- Load then add: ch0 LOAD 0x40, then ch1 ADD 0x05 -> value 0x40 then 0x45, ovf=0, each one cycle after grant.
- Simultaneous requests: all three channels ADD 0x01 held continuously from ptr=0 -> gnt sequence 001,010,100,001…; value +1 per cycle.
- Wrap: value=0xFE, ADD 0x03 -> 0x01 with ovf=1 for one cycle. SUB 0x02 from 0x01 -> 0xFF, ovf=1.
- Saturation build (SHARED_COUNTER_SAT_EN): 0xFE ADD 0x03 -> 0xFF, ovf=1. 0x01 SUB 0x02 -> 0x00, ovf=1.
- Reset mid-request: ch2 requests LOAD 0x99, rst asserted at the same edge -> value=0x00. Next cycle ch2 granted (sole requester) -> value=0x99.
